// File: rtl/game_sprite_mover_pkg.sv
// Shared constants, state encoding and velocity helper for the sprite mover.
package game_sprite_mover_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int X_WIDTH      = 10;
  localparam int Y_WIDTH      = 9;
  localparam int VEL_WIDTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  typedef logic signed [VEL_WIDTH-1:0] vel_t;

  // -8 has no positive counterpart in 4 bits, so a bounce could not negate it.
  function automatic vel_t clamp_vel(input vel_t v);
    return (v == vel_t'(-8)) ? vel_t'(-7) : v;
  endfunction

endpackage

// File: rtl/game_sprite_mover_if.sv
// Control inputs and bounding-box outputs of one sprite mover.
interface game_sprite_mover_if;
  import game_sprite_mover_pkg::*;

  logic                 frame_strobe;
  logic                 launch;
  vel_t                 launch_dx;
  vel_t                 launch_dy;
  logic                 collision;
  logic [X_WIDTH-1:0]   left;
  logic [X_WIDTH-1:0]   right;
  logic [Y_WIDTH-1:0]   top;
  logic [Y_WIDTH-1:0]   bottom;
  logic                 moving;
  logic                 frozen;

  modport master (
    output frame_strobe, launch, launch_dx, launch_dy, collision,
    input  left, right, top, bottom, moving, frozen
  );

  modport slave (
    input  frame_strobe, launch, launch_dx, launch_dy, collision,
    output left, right, top, bottom, moving, frozen
  );

endinterface

// File: rtl/game_axis_step.sv
// One-axis position step with bounce at 0 and EXTENT-SIZE; purely combinational.
module game_axis_step #(
  parameter int WIDTH  = 10,
  parameter int EXTENT = 640,
  parameter int SIZE   = 16
) (
  input  logic [WIDTH-1:0]  pos,
  input  logic signed [3:0] vel,
  input  logic              en,
  output logic [WIDTH-1:0]  next_pos,
  output logic signed [3:0] next_vel
);

  localparam logic signed [WIDTH+1:0] MAX_POS = (WIDTH+2)'(EXTENT - SIZE);

  logic signed [WIDTH+1:0] sum;

  assign sum = $signed({2'b00, pos}) + (WIDTH+2)'(vel);

  always_comb begin
    next_pos = pos;
    next_vel = vel;
    if (en) begin
      if (sum < 0) begin
        next_pos = '0;
        next_vel = -vel;
      end else if (sum > MAX_POS) begin
        next_pos = WIDTH'(EXTENT - SIZE);
        next_vel = -vel;
      end else begin
        next_pos = sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/game_sprite_mover.sv
// Sprite position/velocity owner: bounces off screen edges, freezes on collision.
//   state     | meaning
//   ST_IDLE   | parked at start position, waiting for launch
//   ST_MOVING | position advances on every frame strobe
//   ST_FROZEN | collision seen, position held until relaunch
module game_sprite_mover
  import game_sprite_mover_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int START_X  = 0,
  parameter int START_Y  = 0
) (
  input  logic                clk,
  input  logic                reset,
  game_sprite_mover_if.slave  bus
);

  state_t             state, state_next;
  logic [X_WIDTH-1:0] x, x_next, x_step, right_r;
  logic [Y_WIDTH-1:0] y, y_next, y_step, bottom_r;
  vel_t               dx, dx_next, dx_step;
  vel_t               dy, dy_next, dy_step;
  logic               step_en;
  logic               moving_r, frozen_r;

  game_axis_step #(.WIDTH(X_WIDTH), .EXTENT(SCREEN_W), .SIZE(SPRITE_W)) u_step_x (
    .pos      (x),
    .vel      (dx),
    .en       (step_en),
    .next_pos (x_step),
    .next_vel (dx_step)
  );

  game_axis_step #(.WIDTH(Y_WIDTH), .EXTENT(SCREEN_H), .SIZE(SPRITE_H)) u_step_y (
    .pos      (y),
    .vel      (dy),
    .en       (step_en),
    .next_pos (y_step),
    .next_vel (dy_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    dx_next    = dx;
    dy_next    = dy;
    step_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.launch) begin
          dx_next    = clamp_vel(bus.launch_dx);
          dy_next    = clamp_vel(bus.launch_dy);
          state_next = ST_MOVING;
        end
      end
      ST_MOVING: begin
        // collision outranks a same-cycle strobe: freeze where we stand
        if (bus.collision) begin
          state_next = ST_FROZEN;
        end else if (bus.frame_strobe) begin
          step_en = 1'b1;
          x_next  = x_step;
          y_next  = y_step;
          dx_next = dx_step;
          dy_next = dy_step;
        end
      end
      ST_FROZEN: begin
        if (bus.launch) begin
          x_next     = X_WIDTH'(START_X);
          y_next     = Y_WIDTH'(START_Y);
          dx_next    = clamp_vel(bus.launch_dx);
          dy_next    = clamp_vel(bus.launch_dy);
          state_next = ST_MOVING;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Box edges and status flags are registered from next-state values so they
  // move on the same edge as x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= X_WIDTH'(START_X);
      y        <= Y_WIDTH'(START_Y);
      dx       <= '0;
      dy       <= '0;
      right_r  <= X_WIDTH'(START_X + SPRITE_W - 1);
      bottom_r <= Y_WIDTH'(START_Y + SPRITE_H - 1);
      moving_r <= 1'b0;
      frozen_r <= 1'b0;
    end else begin
      x        <= x_next;
      y        <= y_next;
      dx       <= dx_next;
      dy       <= dy_next;
      right_r  <= x_next + X_WIDTH'(SPRITE_W - 1);
      bottom_r <= y_next + Y_WIDTH'(SPRITE_H - 1);
      moving_r <= (state_next == ST_MOVING);
      frozen_r <= (state_next == ST_FROZEN);
    end
  end

  assign bus.left   = x;
  assign bus.right  = right_r;
  assign bus.top    = y;
  assign bus.bottom = bottom_r;
  assign bus.moving = moving_r;
  assign bus.frozen = frozen_r;

endmodule
